// File: rtl/instr_fetch_if.sv
// Instruction-fetch bundle: instruction memory request/response port plus the
// valid/ready handshake towards decode. master = fetch stage, slave = environment.
interface instr_fetch_if #(
   parameter int ARCH = 32
);
   logic            imem_req_out;
   logic [ARCH-1:0] imem_addr_out;
   logic            imem_gnt_in;
   logic            imem_rvalid_in;
   logic [ARCH-1:0] imem_rdata_in;
   logic            imem_err_in;
   logic [ARCH-1:0] instr_out;
   logic [ARCH-1:0] instr_pc_out;
   logic            instr_valid_out;
   logic            instr_ready_in;

   modport master (
      output imem_req_out, imem_addr_out,
      input  imem_gnt_in, imem_rvalid_in, imem_rdata_in, imem_err_in,
      output instr_out, instr_pc_out, instr_valid_out,
      input  instr_ready_in
   );

   modport slave (
      input  imem_req_out, imem_addr_out,
      output imem_gnt_in, imem_rvalid_in, imem_rdata_in, imem_err_in,
      input  instr_out, instr_pc_out, instr_valid_out,
      output instr_ready_in
   );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding imem transaction per PC, result held for decode.
// Optional misaligned-PC fault enabled by defining FETCH_MISALIGN_CHK_EN.
module instr_fetch #(
   parameter int ARCH           = 32,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [ARCH-1:0] pc_in,
   input  logic            flush_in,
   instr_fetch_if.master   bus,
   output logic            pc_en_out,
   output logic            fetch_err_out,
   output logic            misalign_out
);

   localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, ERR} state_t;

   state_t          state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic            drop_q;
   logic [ARCH-1:0] instr_q;
   logic [ARCH-1:0] instr_pc_q;
   logic            req_c;
   logic [ARCH-1:0] addr_c;
   logic            misalign_hit;
   logic            drop_eff;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      sat_inc = (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   // A flush coinciding with rvalid discards that response as well.
   assign drop_eff = drop_q | flush_in;

   always_comb begin
      state_d      = state_q;
      req_c        = 1'b0;
      addr_c       = '0;
      misalign_hit = 1'b0;
      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            addr_c = pc_in;
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_hit = |pc_in[1:0];
`endif
            if (misalign_hit) begin
               state_d = ERR;
            end else begin
               req_c = 1'b1;
               if (bus.imem_gnt_in) state_d = WAIT;
            end
         end
         WAIT: begin
            if (bus.imem_rvalid_in) begin
               if (drop_eff)              state_d = REQ;
               else if (bus.imem_err_in)  state_d = ERR;
               else                       state_d = HOLD;
            end else if (cnt_q == CNT_MAX) begin
               state_d = ERR;
            end
         end
         HOLD: if (flush_in || bus.instr_ready_in) state_d = REQ;
         ERR:  if (flush_in) state_d = REQ;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         drop_q     <= 1'b0;
         instr_q    <= '0;
         instr_pc_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == REQ && req_c && bus.imem_gnt_in) begin
            instr_pc_q <= pc_in;
            cnt_q      <= '0;
            drop_q     <= 1'b0;
         end
         if (state_q == WAIT) begin
            if (bus.imem_rvalid_in) begin
               drop_q <= 1'b0;
               if (!drop_eff && !bus.imem_err_in) instr_q <= bus.imem_rdata_in;
            end else begin
               cnt_q <= sat_inc(cnt_q);
               if (flush_in) drop_q <= 1'b1;
            end
         end
      end
   end

`ifdef FETCH_MISALIGN_CHK_EN
   logic misalign_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            misalign_q <= 1'b0;
      else if (state_q == REQ && misalign_hit) misalign_q <= 1'b1;
      else if (state_q == ERR && flush_in)     misalign_q <= 1'b0;
   end

   assign misalign_out = misalign_q;
`else
   assign misalign_out = 1'b0;
`endif

   assign bus.imem_req_out    = req_c;
   assign bus.imem_addr_out   = addr_c;
   assign bus.instr_out       = instr_q;
   assign bus.instr_pc_out    = instr_pc_q;
   assign bus.instr_valid_out = (state_q == HOLD);
   assign pc_en_out           = (state_q == HOLD) && bus.instr_ready_in && !flush_in;
   assign fetch_err_out       = (state_q == ERR);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed + randomized bench for instr_fetch; the bench plays PC, memory and decode.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc;
   logic        flush;
   logic        pc_en, fetch_err, misalign;

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   logic [31:0] exp_instr = 32'h0;
   logic [31:0] exp_pc    = 32'h0;
   int gd, rd, hd, kind;

   instr_fetch_if #(.ARCH(32)) bus ();

   instr_fetch #(.ARCH(32), .TIMEOUT_CYCLES(15)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pc_in         (pc),
      .flush_in      (flush),
      .bus           (bus),
      .pc_en_out     (pc_en),
      .fetch_err_out (fetch_err),
      .misalign_out  (misalign)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One bench cycle: drive inputs after the falling edge, then let outputs settle.
   task automatic cyc(input bit g, input bit rv, input logic [31:0] d, input bit e,
                      input bit rdy, input bit fl);
      @(negedge clk);
      bus.imem_gnt_in    = g;
      bus.imem_rvalid_in = rv;
      bus.imem_rdata_in  = d;
      bus.imem_err_in    = e;
      bus.instr_ready_in = rdy;
      flush              = fl;
      #1;
   endtask

   // Request phase: req held with the current PC until granted on cycle gd.
   // Flush and stray rvalid are driven as noise; neither may disturb the request.
   task automatic req_phase(input int g_dly);
      for (int i = 0; i <= g_dly; i++) begin
         cyc(i == g_dly, (i < g_dly) ? 1'($urandom) : 1'b0, $urandom, 1'($urandom),
             1'($urandom), (i < g_dly) ? 1'($urandom) : 1'b0);
         chk("req_high", bus.imem_req_out, 1);
         chk("req_addr", bus.imem_addr_out, pc);
         chk("req_pcen", pc_en, 0);
         chk("req_valid", bus.instr_valid_out, 0);
         chk("req_err", fetch_err, 0);
         chk("req_misalign", misalign, 0);
      end
   endtask

   // Response phase: rvalid on cycle r_dly; flush on cycle fl_at (0 = none).
   task automatic wait_phase(input int r_dly, input logic [31:0] d, input bit e, input int fl_at);
      for (int j = 1; j <= r_dly; j++) begin
         cyc(1'($urandom), j == r_dly, (j == r_dly) ? d : $urandom,
             (j == r_dly) ? e : 1'($urandom), 1'($urandom), j == fl_at);
         chk("wait_req", bus.imem_req_out, 0);
         chk("wait_valid", bus.instr_valid_out, 0);
         chk("wait_pcen", pc_en, 0);
         chk("wait_err", fetch_err, 0);
      end
      if (!(fl_at >= 1 && fl_at <= r_dly) && !e) begin
         exp_instr = d;
         exp_pc    = pc;
      end
   endtask

   // Hold phase: ready rises on cycle h_dly; flush on cycle fl_at (-1 = none).
   task automatic hold_phase(input int h_dly, input int fl_at);
      bit rdy, fl;
      for (int k = 0; k <= h_dly; k++) begin
         rdy = (k == h_dly);
         fl  = (k == fl_at);
         cyc(1'($urandom), 1'($urandom), $urandom, 1'($urandom), rdy, fl);
         chk("hold_valid", bus.instr_valid_out, 1);
         chk("hold_instr", bus.instr_out, exp_instr);
         chk("hold_pc", bus.instr_pc_out, exp_pc);
         chk("hold_req", bus.imem_req_out, 0);
         chk("hold_pcen", pc_en, rdy && !fl);
         if (fl) return;
      end
      pc = pc + 32'd4;
   endtask

   // Error phase: n quiet cycles, then the clearing flush cycle (still in error).
   task automatic err_phase(input int n, input bit exp_mis);
      for (int i = 0; i <= n; i++) begin
         cyc(1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom), i == n);
         chk("err_flag", fetch_err, 1);
         chk("err_misalign", misalign, exp_mis);
         chk("err_req", bus.imem_req_out, 0);
         chk("err_pcen", pc_en, 0);
         chk("err_valid", bus.instr_valid_out, 0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      pc    = 32'h0;
      flush = 1'b0;
      bus.imem_gnt_in = 1'b0; bus.imem_rvalid_in = 1'b0; bus.imem_rdata_in = '0;
      bus.imem_err_in = 1'b0; bus.instr_ready_in = 1'b0;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_req", bus.imem_req_out, 0);
      chk("rst_addr", bus.imem_addr_out, 0);
      chk("rst_valid", bus.instr_valid_out, 0);
      chk("rst_instr", bus.instr_out, 0);
      chk("rst_ipc", bus.instr_pc_out, 0);
      chk("rst_pcen", pc_en, 0);
      chk("rst_err", fetch_err, 0);
      chk("rst_misalign", misalign, 0);
      @(negedge clk); rst_n = 1'b1; #1;
      chk("idle_req", bus.imem_req_out, 0);

      // Best-case fetch at PC 0
      req_phase(0);
      wait_phase(1, 32'h00500093, 1'b0, 0);
      hold_phase(0, -1);
      chk("first_instr", exp_instr, 32'h00500093);

      // Next request shows PC 4, then a slow fetch at 0x10 with a long HOLD
      req_phase(0);
      wait_phase(1, $urandom, 1'b0, 0);
      hold_phase(0, -1);
      pc = 32'h10;
      req_phase(3);
      wait_phase(2, $urandom, 1'b0, 0);
      hold_phase(5, -1);

      // Flush in WAIT drops the response; flush in HOLD drops the instruction
      req_phase(0);
      wait_phase(3, 32'hDEADBEEF, 1'b0, 1);
      req_phase(1);
      wait_phase(1, $urandom, 1'b0, 0);
      hold_phase(3, 1);
      req_phase(0);
      wait_phase(2, $urandom, 1'b1, 2);
      req_phase(0);
      wait_phase(1, $urandom, 1'b0, 0);
      hold_phase(2, 2);

      // Bus error, then rvalid on the last WAIT cycle before timeout
      req_phase(0);
      wait_phase(2, $urandom, 1'b1, 0);
      err_phase(3, 1'b0);
      req_phase(0);
      wait_phase(16, $urandom, 1'b0, 0);
      hold_phase(1, -1);

      // Timeout: 16 WAIT cycles without rvalid, error visible after
      req_phase(0);
      for (int j = 1; j <= 16; j++) begin
         cyc(1'b0, 1'b0, $urandom, 1'b0, 1'b0, 1'b0);
         chk("to_wait_err", fetch_err, 0);
      end
      err_phase(2, 1'b0);

      // Misaligned PC
      pc = 32'h6;
`ifdef FETCH_MISALIGN_CHK_EN
      cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk("mis_req", bus.imem_req_out, 0);
      chk("mis_err_pre", fetch_err, 0);
      err_phase(2, 1'b1);
      pc = 32'h8;
`else
      req_phase(0);
      wait_phase(1, $urandom, 1'b0, 0);
      hold_phase(0, -1);
      chk("mis_ipc", exp_pc, 32'h6);
      pc = 32'h8;
`endif
      req_phase(1);
      wait_phase(1, $urandom, 1'b0, 0);
      hold_phase(0, -1);

      // Asynchronous reset mid-transaction, stale response afterwards
      req_phase(0);
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b0; #1;
      chk("arst_req", bus.imem_req_out, 0);
      chk("arst_instr", bus.instr_out, 0);
      chk("arst_ipc", bus.instr_pc_out, 0);
      chk("arst_err", fetch_err, 0);
      @(negedge clk); rst_n = 1'b1;
      bus.imem_rvalid_in = 1'b1; bus.imem_rdata_in = 32'hBAD0BAD0; #1;
      chk("arst_idle_req", bus.imem_req_out, 0);
      exp_instr = 32'h0; exp_pc = 32'h0;
      req_phase(1);
      wait_phase(2, $urandom, 1'b0, 0);
      hold_phase(1, -1);

      // Randomized fetch sequence
      for (int n = 0; n < 40; n++) begin
         gd   = $urandom_range(0, 3);
         rd   = $urandom_range(1, 5);
         hd   = $urandom_range(0, 4);
         kind = $urandom_range(0, 9);
         req_phase(gd);
         if (kind == 0) begin
            wait_phase(rd, $urandom, 1'($urandom), $urandom_range(1, rd));
         end else if (kind == 1) begin
            wait_phase(rd, $urandom, 1'b1, 0);
            err_phase($urandom_range(0, 2), 1'b0);
         end else begin
            wait_phase(rd, $urandom, 1'b0, 0);
            hold_phase(hd, (kind == 2) ? $urandom_range(0, hd) : -1);
         end
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage directly downstream of the program counter.
- Takes the current PC and runs a request/grant/response transaction on the instruction memory port.
- Holds the returned instruction for decode under a valid/ready handshake.
- Pulses pc_en_out so the PC advances only once its instruction is consumed.
- Also handles flush on redirect, bus errors and response timeout.

Parameters:
ARCH, 32, data/address width (matches package ARCH)
TIMEOUT_CYCLES, 15, max WAIT cycles without imem_rvalid_in before a fetch error (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
pc_in  in  ARCH  current PC value from pc
flush_in  in  1  redirect: discard in-flight/held instruction
imem_req_out  out  1  memory request
imem_addr_out  out  ARCH  memory request address
imem_gnt_in  in  1  request accepted
imem_rvalid_in  in  1  response valid
imem_rdata_in  in  ARCH  response data
imem_err_in  in  1  response error, qualified by rvalid
instr_out  out  ARCH  fetched instruction
instr_pc_out  out  ARCH  address of instr_out
instr_valid_out  out  1  instr_out valid
instr_ready_in  in  1  decode accepts instruction
pc_en_out  out  1  PC update enable, one cycle per consumed instruction
fetch_err_out  out  1  sticky fetch error
misalign_out  out  1  misaligned-PC fault (optional feature)

Behaviour:
- Reset:
  - state IDLE.
  - All outputs 0; instr_out, instr_pc_out and the timeout counter are 0.
- FSM states: IDLE, REQ, WAIT, HOLD, ERR.
- IDLE: moves to REQ unconditionally on the next clock.
- REQ:
  - imem_req_out=1; imem_addr_out=pc_in (combinational).
  - pc_in is stable here because pc_en_out=0.
  - imem_gnt_in=1: latch pc_in into instr_pc_r, clear counter, go to WAIT.
  - flush_in has no effect in REQ; the request is never withdrawn before grant.
- WAIT:
  - Counter increments each cycle without rvalid.
  - rvalid & !err & !drop: instr_out<=rdata, go to HOLD.
  - rvalid & err & !drop: go to ERR.
  - rvalid & drop (either err value): clear drop, go to REQ.
  - Counter == TIMEOUT_CYCLES without rvalid: go to ERR, regardless of drop.
  - flush_in sets drop. A flush in the same cycle as rvalid also discards that response.
- HOLD:
  - instr_valid_out=1; instr_out and instr_pc_out held stable.
  - pc_en_out = instr_ready_in & !flush_in (combinational).
  - ready & !flush: go to REQ. The PC updates on the same edge, so the next REQ presents the new pc_in.
  - flush_in: valid drops next cycle, go to REQ, no pc_en_out pulse.
- ERR:
  - fetch_err_out=1, sticky.
  - No requests issued, pc_en_out=0.
  - Only flush_in clears it: go to REQ, fetch_err_out 0 next cycle.
- Protocol rules:
  - rvalid arrives no earlier than the cycle after gnt.
  - At most one transaction is outstanding.
  - rvalid outside WAIT is ignored.
  - imem_err_in is ignored unless rvalid is high.
- Throughput: best case one instruction per 3 cycles (REQ, WAIT, HOLD) with gnt on first cycle and rvalid on the next.
- Async reset mid-transaction returns to IDLE. Any outstanding memory response after reset is ignored; the memory side is reset by the same rst_n.
- Timeout counter width: $clog2(TIMEOUT_CYCLES+1); it saturates and does not wrap.

Optional Feature:
- Macro FETCH_MISALIGN_CHK_EN.
- Defined:
  - In REQ, if pc_in[1:0]!=0, imem_req_out is held 0 and the FSM goes to ERR next cycle.
  - Both fetch_err_out and misalign_out are set; flush_in clears both.
- Undefined: no check; the address is passed unchanged and misalign_out is tied 0.

Test Plan:
- Reset, pc_in=0x0, gnt on first REQ cycle, rvalid next cycle with rdata=0x00500093, ready=1 -> instr_out=0x00500093, instr_pc_out=0x0, single pc_en_out pulse; next REQ addr = new pc_in 0x4.
- Gnt delayed 3 cycles, rvalid delayed 2 cycles after gnt, pc_in=0x10 -> imem_addr_out stable at 0x10 with req high throughout; no pc_en_out until HOLD & ready.
- HOLD with ready=0 for 5 cycles -> instr_valid_out held 1, outputs stable, pc_en_out=0; ready=1 -> one pc_en_out pulse, valid low next cycle.
- flush_in during WAIT, then rvalid with rdata=0xDEADBEEF -> instr_valid_out never asserts, FSM returns to REQ; flush in HOLD -> valid drops, no pc_en_out.
- rvalid with imem_err_in=1 -> fetch_err_out=1, no further req; TIMEOUT_CYCLES=15 with no rvalid -> fetch_err_out on cycle 16 of WAIT; flush_in clears, req resumes.
- With FETCH_MISALIGN_CHK_EN, pc_in=0x6 -> imem_req_out never asserts, misalign_out=1 and fetch_err_out=1; without the macro -> request issued to 0x6, misalign_out=0.
